// File: rtl/fma16_normround.sv
// fp16 FMA normalize/round/pack: 2-stage valid/ready pipeline after the sum stage.
// Optional FMA16_FLAGS_EN adds registered {overflow, underflow, inexact} flags.
module fma16_normround #(
  parameter int LAT_BYPASS = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [33:0] Sm,
  input  logic [6:0]  Se,
  input  logic        Ss,
  input  logic        ASticky,
  input  logic [1:0]  RoundMode,
  input  logic        Special,
  input  logic [15:0] SpecialResult,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Result,
  output logic [2:0]  Flags
);

  if (LAT_BYPASS != 0) begin : g_lat_chk
    $error("LAT_BYPASS is reserved and must be 0");
  end

  logic        s1_valid_q, s2_valid_q;
  logic [32:0] s1_n_q;
  logic [8:0]  s1_e_q;
  logic        s1_s_q, s1_ast_q, s1_sp_q, s1_z_q;
  logic [1:0]  s1_rm_q;
  logic [15:0] s1_spr_q;
  logic [15:0] res_q, res_d;

  logic s2_adv, s1_ld, s2_ld;
  assign s2_adv    = ~s2_valid_q | out_ready;
  assign in_ready  = ~s1_valid_q | s2_adv;
  assign s1_ld     = in_valid & in_ready;
  assign s2_ld     = s2_adv & s1_valid_q;
  assign out_valid = s2_valid_q;
  assign Result    = res_q;

  logic [5:0]  lzc;
  logic [32:0] n_d;
  logic [8:0]  e_d;

  always_comb begin
    lzc = 6'd34;
    for (int i = 0; i < 34; i++) begin
      if (Sm[i]) lzc = 6'(33 - i);
    end
  end

  // the leading one lands in bit 33 and is implicit, so it is dropped
  assign n_d = 33'(Sm << lzc);
  assign e_d = {{2{Se[6]}}, Se} + 9'd13 - {3'b000, lzc};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_n_q     <= '0;
      s1_e_q     <= '0;
      s1_s_q     <= 1'b0;
      s1_ast_q   <= 1'b0;
      s1_rm_q    <= '0;
      s1_sp_q    <= 1'b0;
      s1_spr_q   <= '0;
      s1_z_q     <= 1'b0;
    end else begin
      if (in_ready) s1_valid_q <= in_valid;
      if (s1_ld) begin
        s1_n_q   <= n_d;
        s1_e_q   <= e_d;
        s1_s_q   <= Ss;
        s1_ast_q <= ASticky;
        s1_rm_q  <= RoundMode;
        s1_sp_q  <= Special;
        s1_spr_q <= SpecialResult;
        s1_z_q   <= (Sm == 34'd0);
      end
    end
  end

  logic [9:0] frac, fr;
  logic [8:0] er;
  logic       g, st, inc, ovf, uf, to_inf;

  assign frac = s1_n_q[32:23];
  assign g    = s1_n_q[22];
  assign st   = (|s1_n_q[21:0]) | s1_ast_q;

  always_comb begin
    inc = 1'b0;
    unique case (s1_rm_q)
      2'b00: inc = 1'b0;
      2'b01: inc = g & (st | frac[0]);
      2'b10: inc = (g | st) & s1_s_q;
      2'b11: inc = (g | st) & ~s1_s_q;
    endcase
  end

  assign {er, fr} = {s1_e_q, frac} + {18'd0, inc};
  assign ovf    = $signed(er) >= 9'sd31;
  assign uf     = $signed(s1_e_q) <= 9'sd0;
  assign to_inf = (s1_rm_q == 2'b01)
                | ((s1_rm_q == 2'b11) & ~s1_s_q)
                | ((s1_rm_q == 2'b10) & s1_s_q);

  always_comb begin
    res_d = {s1_s_q, er[4:0], fr};
    if (s1_sp_q)
      res_d = s1_spr_q;
    else if (s1_z_q & ~s1_ast_q)
      res_d = (s1_rm_q == 2'b10) ? 16'h8000 : 16'h0000;
    else if (s1_z_q | uf)
      res_d = {s1_s_q, 15'd0};
    else if (ovf)
      res_d = to_inf ? {s1_s_q, 15'h7C00} : {s1_s_q, 15'h7BFF};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      res_q      <= '0;
    end else begin
      if (s2_adv) s2_valid_q <= s1_valid_q;
      if (s2_ld)  res_q      <= res_d;
    end
  end

`ifdef FMA16_FLAGS_EN
  logic [2:0] flg_q, flg_d;

  always_comb begin
    flg_d = {2'b00, g | st};
    if (s1_sp_q)
      flg_d = 3'b000;
    else if (s1_z_q & ~s1_ast_q)
      flg_d = 3'b000;
    else if (s1_z_q | uf)
      flg_d = 3'b011;
    else if (ovf)
      flg_d = 3'b101;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      flg_q <= 3'b000;
    else if (s2_ld) flg_q <= flg_d;
  end

  assign Flags = flg_q;
`else
  assign Flags = 3'b000;
`endif

endmodule

// File: tb/tb_fma16_normround.sv
// Directed self-checking bench for fma16_normround.
module tb_fma16_normround;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [33:0] Sm;
  logic [6:0]  Se;
  logic        Ss, ASticky, Special;
  logic [1:0]  RoundMode;
  logic [15:0] SpecialResult;
  logic        out_valid, out_ready;
  logic [15:0] Result;
  logic [2:0]  Flags;

  int total = 0;
  int passed = 0;
  int fails = 0;

  fma16_normround dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .Sm(Sm), .Se(Se), .Ss(Ss), .ASticky(ASticky),
    .RoundMode(RoundMode), .Special(Special),
    .SpecialResult(SpecialResult),
    .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .Flags(Flags)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] RZ = 2'b00, RNE = 2'b01;
  localparam logic [1:0] RM = 2'b10, RP = 2'b11;

  function automatic logic [2:0] fx(input logic [2:0] f);
`ifdef FMA16_FLAGS_EN
    return f;
`else
    return 3'b000 & f;
`endif
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [33:0] sm, input logic [6:0] se,
                        input logic ss, input logic ast,
                        input logic [1:0] rm, input logic sp,
                        input logic [15:0] spr);
    Sm = sm; Se = se; Ss = ss; ASticky = ast;
    RoundMode = rm; Special = sp; SpecialResult = spr;
  endtask

  task automatic run(input string tag, input logic [33:0] sm,
                     input logic [6:0] se, input logic ss,
                     input logic ast, input logic [1:0] rm,
                     input logic sp, input logic [15:0] spr,
                     input logic [15:0] er, input logic [2:0] ef);
    int n;
    set_in(sm, se, ss, ast, rm, sp, spr);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "/valid"}, {15'd0, out_valid}, 16'd1);
    chk(tag, Result, er);
    chk({tag, "/flags"}, {13'd0, Flags}, {13'd0, fx(ef)});
  endtask

  logic [33:0] bsm [4] = '{34'h000100000, 34'h3FFFFFFFF,
                           34'h000100000, 34'h000180000};
  logic [6:0]  bse [4] = '{7'd15, 7'd2, 7'd14, 7'd16};
  logic [15:0] bex [4] = '{16'h3C00, 16'h4000, 16'h3800, 16'h4200};

  initial begin
    int idx, got, c;
    logic acc;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    set_in(34'd0, 7'd0, 1'b0, 1'b0, RNE, 1'b0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rst/out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst/result", Result, 16'h0000);
    chk("rst/flags", {13'd0, Flags}, 16'd0);
    reset = 1'b0;
    #1;
    chk("rst/in_ready", {15'd0, in_ready}, 16'd1);

    // latency: accept at this edge, visible two cycles later
    @(negedge clk);
    set_in(34'h000100000, 7'd15, 1'b0, 1'b0, RNE, 1'b0, 16'h0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("one/lat1", {15'd0, out_valid}, 16'd0);
    @(negedge clk);
    chk("one/lat2", {15'd0, out_valid}, 16'd1);
    chk("one", Result, 16'h3C00);
    chk("one/flags", {13'd0, Flags}, {13'd0, fx(3'b000)});

    run("carry_rne", 34'h3FFFFFFFF, 7'd2, 0, 0, RNE, 0, 0, 16'h4000, 3'b001);
    run("carry_rz",  34'h3FFFFFFFF, 7'd2, 0, 0, RZ,  0, 0, 16'h3FFF, 3'b001);
    run("carry_rm",  34'h3FFFFFFFF, 7'd2, 1, 0, RM,  0, 0, 16'hC000, 3'b001);
    run("neg_rp",    34'h3FFFFFFFF, 7'd2, 1, 0, RP,  0, 0, 16'hBFFF, 3'b001);
    run("tie_even",  34'h000100200, 7'd15, 0, 0, RNE, 0, 0, 16'h3C00, 3'b001);
    run("tie_odd",   34'h000100600, 7'd15, 0, 0, RNE, 0, 0, 16'h3C02, 3'b001);
    run("ovf_rne",   34'h000100000, 7'd40, 0, 0, RNE, 0, 0, 16'h7C00, 3'b101);
    run("ovf_rz",    34'h000100000, 7'd40, 0, 0, RZ,  0, 0, 16'h7BFF, 3'b101);
    run("ovf_rp_n",  34'h000100000, 7'd40, 1, 0, RP,  0, 0, 16'hFBFF, 3'b101);
    run("ovf_rm_n",  34'h000100000, 7'd40, 1, 0, RM,  0, 0, 16'hFC00, 3'b101);
    run("ovf_round", 34'h3FFFFFFFF, 7'd17, 0, 0, RNE, 0, 0, 16'h7C00, 3'b101);
    run("max_rz",    34'h3FFFFFFFF, 7'd17, 0, 0, RZ,  0, 0, 16'h7BFF, 3'b001);
    run("emin",      34'h000100000, 7'd1,  0, 0, RNE, 0, 0, 16'h0400, 3'b000);
    run("uf",        34'h000100000, 7'd0,  0, 0, RNE, 0, 0, 16'h0000, 3'b011);
    run("uf_neg",    34'h000100000, 7'd0,  1, 0, RNE, 0, 0, 16'h8000, 3'b011);
    run("zero_rne",  34'h0, 7'd0, 0, 0, RNE, 0, 0, 16'h0000, 3'b000);
    run("zero_rm",   34'h0, 7'd0, 0, 0, RM,  0, 0, 16'h8000, 3'b000);
    run("zero_st",   34'h0, 7'd0, 1, 1, RNE, 0, 0, 16'h8000, 3'b011);
    run("special", 34'h3FFFFFFFF, 7'd40, 0, 0, RNE, 1, 16'h7E00,
        16'h7E00, 3'b000);

    // backpressure: out_ready low for the first 4 cycles
    @(negedge clk);
    idx = 0; got = 0; acc = 1'b0;
    for (c = 0; c < 40 && got < 4; c++) begin
      out_ready = (c >= 4);
      #1;
      if (c == 2) chk("bp/in_ready_drop", {15'd0, in_ready}, 16'd0);
      if (c == 2 || c == 3) begin
        chk("bp/stall_valid", {15'd0, out_valid}, 16'd1);
        chk("bp/stall_hold", Result, bex[0]);
      end
      if (out_valid && out_ready) begin
        chk("bp/order", Result, bex[got]);
        got++;
      end
      if (acc) idx++;
      if (idx < 4) begin
        set_in(bsm[idx], bse[idx], 1'b0, 1'b0, RNE, 1'b0, 16'h0);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid & in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp/count", 16'(got), 16'd4);
    #1;
    chk("bp/no_dup", {15'd0, out_valid}, 16'd0);

    // reset with both stages full
    @(negedge clk);
    out_ready = 1'b0;
    set_in(34'h000100000, 7'd15, 0, 0, RNE, 0, 0);
    in_valid = 1'b1;
    @(negedge clk);
    set_in(34'h000100000, 7'd14, 0, 0, RNE, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("full/out_valid", {15'd0, out_valid}, 16'd1);
    chk("full/in_ready", {15'd0, in_ready}, 16'd0);
    reset = 1'b1;
    #1;
    chk("midrst/out_valid", {15'd0, out_valid}, 16'd0);
    chk("midrst/result", Result, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("midrst/in_ready", {15'd0, in_ready}, 16'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst/stale", {15'd0, out_valid}, 16'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
